// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   arbState_t : arbiter state (idle, lane 0 owns the port, lane 1 owns it)
//   LANE0/LANE1: lane index constants used for the round-robin pointer
//   satInc     : saturating increment for 32-bit event counters
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arbState_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != {PERF_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two lane request/response ports and the data-memory port.
//   master : core lanes plus memory (drive requests and mem_rdata)
//   slave  : the arbiter (drives ready, responses and mem_we/addr/wdata)
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0_valid;
  logic              req0_we;
  logic              req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic              req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-lane read response register.
//   clk, reset : clock and asynchronous active-high reset
//   capture    : a read from this lane was granted this cycle
//   memRdata   : combinational read data from the data memory
//   rspValid   : one-cycle pulse the cycle after a granted read
//   rspRdata   : last read data, held until the next read of this lane
module dmem_rsp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] memRdata,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspRdata
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rspValid <= 1'b0;
      rspRdata <= '0;
    end else begin
      rspValid <= capture;
      if (capture) rspRdata <= memRdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-lane arbiter for the single-ported data memory.
// One access is granted per cycle with round-robin priority between lanes;
// a granted access with lock=1 gives that lane exclusive ownership until it
// issues an unlocking access or the lock has been held LOCK_MAX cycles.
// Read data comes back through a registered response one cycle after grant.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lane request/response ports and data-memory port (slave)
// Optional build macro DMEM_ARB_PERF_EN adds saturating counters and ports:
//   perf_grant0, perf_grant1, perf_conflict, perf_lock_timeout
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_grant0,
  output logic [PERF_W-1:0] perf_grant1,
  output logic [PERF_W-1:0] perf_conflict,
  output logic [PERF_W-1:0] perf_lock_timeout
`endif
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arbState_t        state;
  logic             rrPtr;
  logic [CNT_W-1:0] lockCnt;

  logic grant0;
  logic grant1;
  logic anyGrant;
  logic grantLane;
  logic grantLock;
  logic bothValid;

  assign bothValid = bus.req0_valid & bus.req1_valid;
  assign anyGrant  = grant0 | grant1;
  assign grantLane = grant1 ? LANE1 : LANE0;
  assign grantLock = grant1 ? bus.req1_lock : bus.req0_lock;

  // Grant decode: reset forces no grant so nothing reaches the memory
  // while the arbiter state is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (bothValid) begin
            grant0 = (rrPtr == LANE0);
            grant1 = (rrPtr == LANE1);
          end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
          end
        end
        ST_OWN0: grant0 = bus.req0_valid;
        ST_OWN1: grant1 = bus.req1_valid;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant0) begin
      bus.mem_we    = bus.req0_we;
      bus.mem_addr  = bus.req0_addr;
      bus.mem_wdata = bus.req0_wdata;
    end else if (grant1) begin
      bus.mem_we    = bus.req1_we;
      bus.mem_addr  = bus.req1_addr;
      bus.mem_wdata = bus.req1_wdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic lockTimeout;
`endif

  // Ownership state machine. The lock counter runs every owned cycle,
  // granted or not, so an owner that stalls cannot starve the other lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rrPtr   <= LANE0;
      lockCnt <= '0;
`ifdef DMEM_ARB_PERF_EN
      lockTimeout <= 1'b0;
`endif
    end else begin
`ifdef DMEM_ARB_PERF_EN
      lockTimeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (anyGrant) begin
            if (bothValid) rrPtr <= ~grantLane;
            if (grantLock) begin
              state   <= (grantLane == LANE1) ? ST_OWN1 : ST_OWN0;
              lockCnt <= '0;
            end
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (lockCnt == CNT_LAST) begin
            state   <= ST_IDLE;
            rrPtr   <= (state == ST_OWN0) ? LANE1 : LANE0;
            lockCnt <= '0;
`ifdef DMEM_ARB_PERF_EN
            lockTimeout <= 1'b1;
`endif
          end else if (anyGrant && !grantLock) begin
            state   <= ST_IDLE;
            rrPtr   <= ~grantLane;
            lockCnt <= '0;
          end else begin
            lockCnt <= lockCnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          lockCnt <= '0;
        end
      endcase
    end
  end

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp0 (
    .clk      (clk),
    .reset    (reset),
    .capture  (grant0 & ~bus.req0_we),
    .memRdata (bus.mem_rdata),
    .rspValid (bus.rsp0_valid),
    .rspRdata (bus.rsp0_rdata)
  );

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp1 (
    .clk      (clk),
    .reset    (reset),
    .capture  (grant1 & ~bus.req1_we),
    .memRdata (bus.mem_rdata),
    .rspValid (bus.rsp1_valid),
    .rspRdata (bus.rsp1_rdata)
  );

`ifdef DMEM_ARB_PERF_EN
  // Both lanes valid means exactly one of them is stalled this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grant0       <= '0;
      perf_grant1       <= '0;
      perf_conflict     <= '0;
      perf_lock_timeout <= '0;
    end else begin
      perf_grant0       <= satInc(perf_grant0, grant0);
      perf_grant1       <= satInc(perf_grant1, grant1);
      perf_conflict     <= satInc(perf_conflict, bothValid & anyGrant);
      perf_lock_timeout <= satInc(perf_lock_timeout, lockTimeout);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perfGrant0, perfGrant1, perfConflict, perfLockTimeout;
`endif

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_grant0       (perfGrant0),
    .perf_grant1       (perfGrant1),
    .perf_conflict     (perfConflict),
    .perf_lock_timeout (perfLockTimeout)
`endif
  );

  // Behavioural data memory: combinational read, write on the clock edge.
  logic [31:0] memArr [64];
  assign bus.mem_rdata = memArr[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) memArr[bus.mem_addr[7:2]] <= bus.mem_wdata;

  task automatic setLane(input int n, input logic v, input logic we, input logic lk,
                         input logic [31:0] ad, input logic [31:0] wd);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_lock = lk;
      bus.req0_addr = ad; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_lock = lk;
      bus.req1_addr = ad; bus.req1_wdata = wd;
    end
  endtask

  task automatic idleLanes();
    setLane(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    setLane(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleLanes();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    setLane(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1);
    setLane(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h2);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b%b want=00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we);
    end
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
        bus.rsp0_rdata !== 32'h0 || bus.rsp1_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rsp got=%b%b %h %h want=00 0 0", bus.rsp0_valid,
                           bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata);
    end
    doReset();
  endtask

  task automatic test_single_lane();
    setLane(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 ||
        bus.mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got=rdy%b we%b %h %h want=rdy1 we1 00000040 deadbeef",
                           bus.req0_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    nextCycle();
    setLane(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
      failures++; $display("FAIL single_read_grant got=rdy%b we%b rv%b want=rdy1 we0 rv0",
                           bus.req0_ready, bus.mem_we, bus.rsp0_valid);
    end
    nextCycle();
    idleLanes();
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_read_rsp got=%b %h want=1 deadbeef", bus.rsp0_valid, bus.rsp0_rdata);
    end
    nextCycle();
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp0_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_rsp_hold got=%b %h want=0 deadbeef", bus.rsp0_valid, bus.rsp0_rdata);
    end
  endtask

  task automatic test_conflict();
    setLane(1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h12345678);
    nextCycle();
    doReset();
    for (int k = 0; k < 4; k++) begin
      setLane(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      setLane(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
      #2;
      checks++;
      if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
        failures++; $display("FAIL conflict_grant k=%0d got=%b%b want=%b%b", k, bus.req0_ready,
                             bus.req1_ready, (k % 2 == 0), (k % 2 == 1));
      end
      nextCycle();
      checks++;
      if (bus.rsp0_valid !== (k % 2 == 0) || bus.rsp1_valid !== (k % 2 == 1) ||
          (k % 2 == 0 && bus.rsp0_rdata !== 32'hDEADBEEF) ||
          (k % 2 == 1 && bus.rsp1_rdata !== 32'h12345678)) begin
        failures++; $display("FAIL conflict_rsp k=%0d got=%b%b %h %h", k, bus.rsp0_valid,
                             bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata);
      end
    end
    idleLanes();
    nextCycle();
  endtask

  task automatic test_lock();
    doReset();
    // Lane 0 wins the first conflict so lane 1 holds priority next.
    setLane(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    setLane(1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL lock_pre got=%b%b want=10", bus.req0_ready, bus.req1_ready);
    end
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      setLane(1, 1'b1, 1'b1, (k < 3), 32'h80, 32'(k + 2));
      #2;
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
        failures++; $display("FAIL lock_own k=%0d got=%b%b want=01", k, bus.req0_ready, bus.req1_ready);
      end
    end
    nextCycle();
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL lock_release got=%b%b want=10", bus.req0_ready, bus.req1_ready);
    end
    nextCycle();
    idleLanes();
  endtask

  task automatic test_lock_timeout();
    doReset();
    setLane(0, 1'b1, 1'b1, 1'b1, 32'h90, 32'h55);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_grant got=%b want=1", bus.req0_ready);
    end
    nextCycle();
    setLane(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    setLane(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    for (int k = 1; k <= LOCK_MAX + 1; k++) begin
      #2;
      checks++;
      if (bus.req1_ready !== (k == LOCK_MAX + 1)) begin
        failures++; $display("FAIL timeout_wait k=%0d got=%b want=%b", k, bus.req1_ready, (k == LOCK_MAX + 1));
      end
      nextCycle();
    end
    idleLanes();
  endtask

  task automatic test_mid_lock_reset();
    doReset();
    setLane(1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
    nextCycle();
    setLane(1, 1'b1, 1'b1, 1'b1, 32'h48, 32'hA5A5A5A5);
    #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_rdata !== 32'h12345678 || bus.mem_we !== 1'b1) begin
      failures++; $display("FAIL midlock_pre got=%b %h we%b want=1 12345678 we1",
                           bus.rsp1_valid, bus.rsp1_rdata, bus.mem_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.rsp1_valid !== 1'b0 || bus.rsp1_rdata !== 32'h0 || bus.mem_we !== 1'b0 ||
        bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL midlock_reset got=%b %h we%b rdy%b want=0 0 we0 rdy0",
                           bus.rsp1_valid, bus.rsp1_rdata, bus.mem_we, bus.req1_ready);
    end
    nextCycle();
    reset = 1'b0;
    setLane(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    setLane(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    #2;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++; $display("FAIL midlock_after got=%b%b want=10", bus.req0_ready, bus.req1_ready);
    end
    nextCycle();
    idleLanes();
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf();
    doReset();
    setLane(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    setLane(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    for (int k = 0; k < 6; k++) nextCycle();
    idleLanes();
    nextCycle();
    checks++;
    if (perfConflict !== 32'd6 || perfGrant0 + perfGrant1 !== 32'd6) begin
      failures++; $display("FAIL perf got=conf%0d g0=%0d g1=%0d want=conf6 sum6",
                           perfConflict, perfGrant0, perfGrant1);
    end
  endtask
`endif

  // Randomised traffic checked against a transaction-level model: the model
  // tracks who owns the port, how long it has held it, and the memory image.
  task automatic test_random();
    logic        v  [2];
    logic        we [2];
    logic        lk [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] mMem [64];
    logic        mRspV [2];
    logic [31:0] mRspD [2];
    int owner, rr, held, eg;
    logic        eWe;
    logic [31:0] eAddr, eData;
    doReset();
    for (int i = 0; i < 64; i++) mMem[i] = memArr[i];
    owner = -1; rr = 0; held = 0;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; we[n] = 1'b0; lk[n] = 1'b0; ad[n] = 0; wd[n] = 0;
      mRspV[n] = 1'b0; mRspD[n] = 32'h0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && $urandom_range(0, 9) < 7) begin
          v[n]  = 1'b1;
          we[n] = 1'($urandom_range(0, 1));
          lk[n] = ($urandom_range(0, 3) == 0);
          ad[n] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          wd[n] = $urandom;
        end
        setLane(n, v[n], we[n], lk[n], ad[n], wd[n]);
      end
      if (owner < 0) eg = (v[0] && v[1]) ? rr : (v[0] ? 0 : (v[1] ? 1 : -1));
      else           eg = v[owner] ? owner : -1;
      eWe   = (eg >= 0) ? we[eg] : 1'b0;
      eAddr = (eg >= 0) ? ad[eg] : 32'h0;
      eData = (eg >= 0) ? wd[eg] : 32'h0;
      #2;
      checks++;
      if (bus.req0_ready !== (eg == 0) || bus.req1_ready !== (eg == 1)) begin
        failures++; $display("FAIL rand_grant cyc=%0d got=%b%b want_lane=%0d", cyc,
                             bus.req0_ready, bus.req1_ready, eg);
      end
      checks++;
      if (bus.mem_we !== eWe || bus.mem_addr !== eAddr || bus.mem_wdata !== eData) begin
        failures++; $display("FAIL rand_mem cyc=%0d got=%b %h %h want=%b %h %h", cyc,
                             bus.mem_we, bus.mem_addr, bus.mem_wdata, eWe, eAddr, eData);
      end
      checks++;
      if (bus.rsp0_valid !== mRspV[0] || bus.rsp0_rdata !== mRspD[0] ||
          bus.rsp1_valid !== mRspV[1] || bus.rsp1_rdata !== mRspD[1]) begin
        failures++; $display("FAIL rand_rsp cyc=%0d got=%b %h %b %h want=%b %h %b %h", cyc,
                             bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata,
                             mRspV[0], mRspD[0], mRspV[1], mRspD[1]);
      end
      for (int n = 0; n < 2; n++) begin
        mRspV[n] = (eg == n) && !we[n];
        if (mRspV[n]) mRspD[n] = mMem[ad[n][7:2]];
      end
      if (eg >= 0 && we[eg]) mMem[ad[eg][7:2]] = wd[eg];
      if (owner < 0) begin
        if (eg >= 0) begin
          if (v[0] && v[1]) rr = 1 - eg;
          if (lk[eg]) begin owner = eg; held = 1; end
        end
      end else if (held == LOCK_MAX) begin
        rr = 1 - owner; owner = -1; held = 0;
      end else if (eg >= 0 && !lk[eg]) begin
        rr = 1 - eg; owner = -1; held = 0;
      end else begin
        held++;
      end
      if (eg >= 0) v[eg] = 1'b0;
      nextCycle();
    end
    idleLanes();
  endtask

  initial begin
    idleLanes();
    reset = 1'b1;
    #3;
    test_reset();
    test_single_lane();
    test_conflict();
    test_lock();
    test_lock_timeout();
    test_mid_lock_reset();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between two load/store requesters: lane 0 and lane 1 of the superscalar core.
- Sits between the core's two memory-stage ports and the data memory. The data memory has a combinational read and writes on the clock edge when WE is high.
- Grants one access per cycle using round-robin priority, with a lock mechanism that gives a lane exclusive ownership for read-modify-write sequences.
- Returns read data through a registered response, one cycle after the grant.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, width of the data word.
- LOCK_MAX, 8, maximum number of consecutive cycles a lane may hold a lock before it is force-released.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  lane 0 has an access pending.
- req0_we  input  1  lane 0 access is a write (1) or a read (0).
- req0_lock  input  1  lane 0 keeps ownership after this access.
- req0_addr  input  ADDR_W  lane 0 address.
- req0_wdata  input  DATA_W  lane 0 write data.
- req0_ready  output  1  lane 0 access is accepted this cycle.
- rsp0_valid  output  1  lane 0 read data is valid.
- rsp0_rdata  output  DATA_W  lane 0 read data.
- req1_* / rsp1_*  same as lane 0, for lane 1.
- mem_we  output  1  write enable to the data memory.
- mem_addr  output  ADDR_W  address to the data memory.
- mem_wdata  output  DATA_W  write data to the data memory.
- mem_rdata  input  DATA_W  combinational read data from the data memory.

Behaviour:
- Handshake: an access transfers in a cycle when reqN_valid and reqN_ready are both 1.
  - ready is a combinational function of valid, state and priority pointer.
  - A requester holds valid, we, addr, wdata and lock stable until accepted.
- Grant is one-hot or zero. The mem_* outputs mux the granted lane's signals.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- State machine with states IDLE, OWN0, OWN1.
  - IDLE, one lane valid: grant that lane.
  - IDLE, both lanes valid: grant the lane selected by the rr pointer. rr then points to the other lane.
  - Granted access with lock=1: go to OWNn and load lock_cnt=0. With lock=0: stay in IDLE.
  - OWNn: only lane n can be granted; the other lane's ready=0.
    - Granted access with lock=0: return to IDLE, rr points to the other lane.
    - Granted access with lock=1: stay in OWNn, lock_cnt increments.
    - Each cycle in OWNn with no grant also increments lock_cnt.
  - lock_cnt reaching LOCK_MAX-1 forces IDLE next cycle, rr points to the other lane, and the lock_timeout flag pulses for one cycle (internal, visible with the optional feature).
- Read response:
  - On a granted read, mem_rdata is registered into rspN_rdata and rspN_valid=1 in the next cycle, for exactly one cycle.
  - Writes produce no response.
  - Back-to-back reads by the same lane give consecutive response pulses.
  - A response register holds its data until the next read for that lane.
- Latency: write takes effect at the grant edge; read data appears 1 cycle after the grant.
- Reset (asynchronous, any time, including mid-lock):
  - state=IDLE, rr points to lane 0, lock_cnt=0.
  - rsp0/1_valid=0, rsp0/1_rdata=0.
  - While reset is high: req0/1_ready=0 and mem_we=0.
- Simultaneous events:
  - A lock request from the lane that lost arbitration has no effect until that lane is granted.
  - Both lanes writing the same address is impossible in one cycle; the order follows the grant order.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds 32-bit saturating counters perf_grant0, perf_grant1, perf_conflict and perf_lock_timeout. perf_conflict counts cycles with both lanes valid and one lane stalled.
  - Adds output ports for those counters.
  - All counters reset to 0.
- Undefined: none of these counters or ports exist; the arbitration behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Lane index constants LANE0=1'b0, LANE1=1'b1.
- One sub-module: dmem_rsp_reg. It is one instance per lane and holds the registered response valid and data.

Test Plan:
- Single lane: lane 0 writes 0xDEADBEEF to 0x40, then reads 0x40 → req0_ready=1 in both cycles; rsp0_valid=1 and rsp0_rdata=0xDEADBEEF one cycle after the read grant.
- Conflict: both lanes present reads for 4 cycles after reset → grants alternate 0,1,0,1; each rspN_valid pulses one cycle after its grant.
- Lock: lane 1 is granted with lock=1 for 3 accesses then lock=0 while lane 0 is continuously valid → req0_ready=0 for those 3 accesses; lane 0 is granted in the cycle after the unlocking access.
- Lock timeout: lane 0 is granted with lock=1 and then stays idle with LOCK_MAX=8 → state returns to IDLE after 8 cycles; lane 1 is granted the next cycle.
- Mid-lock reset: assert reset while in OWN1 with a read response pending → rsp1_valid=0 immediately and mem_we=0; after release, with both lanes valid, lane 0 is granted first.
- With DMEM_ARB_PERF_EN defined: run the conflict test for 6 cycles → perf_conflict=6 and perf_grant0 + perf_grant1 = 6.
